// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped UART on the CPU RAM port.
// Registers (addr_i[3:2]): 0 TXDATA, 1 STATUS, 2 DIV, 3 RXDATA.
// Transmit bytes are buffered in a FIFO and sent as 8N1 frames.
// Define MMIO_UART_RX_EN to build the receive path. Without it, rx_i is
// ignored and the RX status bits and RXDATA read as zero.
module mmio_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        sel_o,
  output logic        tx_o,
  input  logic        rx_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  // Register decode
  logic w_wr;
  logic w_wrTx;
  logic w_wrStatus;
  logic w_wrDiv;
  logic w_wrRx;

  assign sel_o      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_wr       = we_i & sel_o;
  assign w_wrTx     = w_wr & (addr_i[3:2] == 2'd0);
  assign w_wrStatus = w_wr & (addr_i[3:2] == 2'd1);
  assign w_wrDiv    = w_wr & (addr_i[3:2] == 2'd2);
  assign w_wrRx     = w_wr & (addr_i[3:2] == 2'd3);

  // Low address bits and the upper write-data bits have no meaning here
  logic w_unusedBits;
  assign w_unusedBits = ^{addr_i[1:0], data_i[31:16]};

  // TX FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_fifoFull;
  logic          w_fifoEmpty;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [7:0]    w_head;

  assign w_fifoFull  = (r_count == DEPTH_C);
  assign w_fifoEmpty = (r_count == '0);
  assign w_push      = w_wrTx & ~w_fifoFull;
  assign w_drop      = w_wrTx & w_fifoFull;
  assign w_head      = r_mem[r_rdPtr];

  // FIFO data array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= data_i[7:0];
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Divisor register and the sticky transmit-drop flag
  logic [15:0] r_div;
  logic        r_txDrop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= CLK_DIV;
      r_txDrop <= 1'b0;
    end else begin
      if (w_wrDiv) r_div <= (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
      if (w_drop)          r_txDrop <= 1'b1;
      else if (w_wrStatus) r_txDrop <= 1'b0;
    end
  end

  // Transmitter state
  txState_t    r_txState;
  txState_t    w_txStateNext;
  logic [15:0] r_txTimer;
  logic [15:0] w_txTimerNext;
  logic [2:0]  r_txBitIdx;
  logic [2:0]  w_txBitIdxNext;
  logic [7:0]  r_txShift;
  logic [7:0]  w_txShiftNext;
  logic        w_txTimerDone;

  assign w_txTimerDone = (r_txTimer == 16'd0);

  // Transmitter registers; reset returns the line to idle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txState  <= TX_IDLE;
      r_txTimer  <= 16'd0;
      r_txBitIdx <= 3'd0;
      r_txShift  <= 8'd0;
    end else begin
      r_txState  <= w_txStateNext;
      r_txTimer  <= w_txTimerNext;
      r_txBitIdx <= w_txBitIdxNext;
      r_txShift  <= w_txShiftNext;
    end
  end

  // Transmitter sequencing: each bit reloads the timer from DIV and runs to 0
  always_comb begin
    w_txStateNext  = r_txState;
    w_txTimerNext  = r_txTimer;
    w_txBitIdxNext = r_txBitIdx;
    w_txShiftNext  = r_txShift;
    w_pop          = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop         = 1'b1;
          w_txStateNext = TX_START;
          w_txTimerNext = r_div;
          w_txShiftNext = w_head;
        end
      end
      TX_START: begin
        if (w_txTimerDone) begin
          w_txStateNext  = TX_DATA;
          w_txTimerNext  = r_div;
          w_txBitIdxNext = 3'd0;
        end else begin
          w_txTimerNext = r_txTimer - 16'd1;
        end
      end
      TX_DATA: begin
        if (w_txTimerDone) begin
          w_txTimerNext = r_div;
          w_txShiftNext = {1'b0, r_txShift[7:1]};
          if (r_txBitIdx == 3'd7) begin
            w_txStateNext = TX_STOP;
          end else begin
            w_txBitIdxNext = r_txBitIdx + 3'd1;
          end
        end else begin
          w_txTimerNext = r_txTimer - 16'd1;
        end
      end
      TX_STOP: begin
        if (w_txTimerDone) begin
          if (!w_fifoEmpty) begin
            w_pop         = 1'b1;
            w_txStateNext = TX_START;
            w_txTimerNext = r_div;
            w_txShiftNext = w_head;
          end else begin
            w_txStateNext = TX_IDLE;
          end
        end else begin
          w_txTimerNext = r_txTimer - 16'd1;
        end
      end
      default: w_txStateNext = TX_IDLE;
    endcase
  end

  // Serial line level follows the current frame position
  always_comb begin
    case (r_txState)
      TX_START: tx_o = 1'b0;
      TX_DATA:  tx_o = r_txShift[0];
      default:  tx_o = 1'b1;
    endcase
  end

  // Receive path results seen by the register file
  logic       w_rxValid;
  logic       w_rxOverrun;
  logic       w_rxFrameErr;
  logic [7:0] w_rxByte;

`ifdef MMIO_UART_RX_EN
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_DONE
  } rxState_t;

  logic        r_rxSync1;
  logic        r_rxSync2;
  logic        r_rxPrev;
  rxState_t    r_rxState;
  rxState_t    w_rxStateNext;
  logic [15:0] r_rxTimer;
  logic [15:0] w_rxTimerNext;
  logic [2:0]  r_rxBitIdx;
  logic [2:0]  w_rxBitIdxNext;
  logic [7:0]  r_rxShift;
  logic [7:0]  w_rxShiftNext;
  logic        r_rxStopBit;
  logic        w_rxStopBitNext;
  logic        w_rxLoad;
  logic        w_rxOverrunSet;
  logic        w_rxFrameErrSet;
  logic [7:0]  r_rxByte;
  logic        r_rxValid;
  logic        r_rxOverrun;
  logic        r_rxFrameErr;
  logic        w_rxFall;
  logic [15:0] w_rxHalfBit;
  logic [15:0] w_rxHalfWait;

  assign w_rxFall     = r_rxPrev & ~r_rxSync2;
  assign w_rxHalfBit  = {1'b0, r_div[15:1]} + {15'd0, r_div[0]};
  assign w_rxHalfWait = (w_rxHalfBit == 16'd0) ? 16'd0 : w_rxHalfBit - 16'd1;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxSync1 <= rx_i;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
    end
  end

  // Receiver registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxState   <= RX_IDLE;
      r_rxTimer   <= 16'd0;
      r_rxBitIdx  <= 3'd0;
      r_rxShift   <= 8'd0;
      r_rxStopBit <= 1'b1;
    end else begin
      r_rxState   <= w_rxStateNext;
      r_rxTimer   <= w_rxTimerNext;
      r_rxBitIdx  <= w_rxBitIdxNext;
      r_rxShift   <= w_rxShiftNext;
      r_rxStopBit <= w_rxStopBitNext;
    end
  end

  // Receiver sequencing: half-bit wait to the start-bit centre, then full bits
  always_comb begin
    w_rxStateNext   = r_rxState;
    w_rxTimerNext   = r_rxTimer;
    w_rxBitIdxNext  = r_rxBitIdx;
    w_rxShiftNext   = r_rxShift;
    w_rxStopBitNext = r_rxStopBit;
    w_rxLoad        = 1'b0;
    w_rxOverrunSet  = 1'b0;
    w_rxFrameErrSet = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        if (w_rxFall) begin
          w_rxStateNext = RX_START;
          w_rxTimerNext = w_rxHalfWait;
        end
      end
      RX_START: begin
        if (r_rxTimer == 16'd0) begin
          if (!r_rxSync2) begin
            w_rxStateNext  = RX_DATA;
            w_rxTimerNext  = r_div;
            w_rxBitIdxNext = 3'd0;
          end else begin
            w_rxStateNext = RX_IDLE;
          end
        end else begin
          w_rxTimerNext = r_rxTimer - 16'd1;
        end
      end
      RX_DATA: begin
        if (r_rxTimer == 16'd0) begin
          w_rxShiftNext = {r_rxSync2, r_rxShift[7:1]};
          w_rxTimerNext = r_div;
          if (r_rxBitIdx == 3'd7) begin
            w_rxStateNext = RX_STOP;
          end else begin
            w_rxBitIdxNext = r_rxBitIdx + 3'd1;
          end
        end else begin
          w_rxTimerNext = r_rxTimer - 16'd1;
        end
      end
      RX_STOP: begin
        if (r_rxTimer == 16'd0) begin
          w_rxStopBitNext = r_rxSync2;
          w_rxStateNext   = RX_DONE;
        end else begin
          w_rxTimerNext = r_rxTimer - 16'd1;
        end
      end
      RX_DONE: begin
        w_rxStateNext = RX_IDLE;
        if (!r_rxStopBit)   w_rxFrameErrSet = 1'b1;
        else if (r_rxValid) w_rxOverrunSet  = 1'b1;
        else                w_rxLoad        = 1'b1;
      end
      default: w_rxStateNext = RX_IDLE;
    endcase
  end

  // Received byte and flags; new events win over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxByte     <= 8'd0;
      r_rxValid    <= 1'b0;
      r_rxOverrun  <= 1'b0;
      r_rxFrameErr <= 1'b0;
    end else begin
      if (w_rxLoad) begin
        r_rxByte  <= r_rxShift;
        r_rxValid <= 1'b1;
      end else if (w_wrRx) begin
        r_rxValid <= 1'b0;
      end
      if (w_rxOverrunSet)  r_rxOverrun <= 1'b1;
      else if (w_wrStatus) r_rxOverrun <= 1'b0;
      if (w_rxFrameErrSet) r_rxFrameErr <= 1'b1;
      else if (w_wrStatus) r_rxFrameErr <= 1'b0;
    end
  end

  assign w_rxValid    = r_rxValid;
  assign w_rxOverrun  = r_rxOverrun;
  assign w_rxFrameErr = r_rxFrameErr;
  assign w_rxByte     = r_rxByte;
`else
  logic w_unusedRx;
  assign w_unusedRx   = rx_i ^ w_wrRx;
  assign w_rxValid    = 1'b0;
  assign w_rxOverrun  = 1'b0;
  assign w_rxFrameErr = 1'b0;
  assign w_rxByte     = 8'd0;
`endif

  // Status word assembly with the FIFO count saturated to 8 bits
  logic [31:0] w_count32;
  logic [7:0]  w_countSat;
  logic [31:0] w_status;
  logic [31:0] w_rdData;

  assign w_count32  = 32'(r_count);
  assign w_countSat = (w_count32 > 32'd255) ? 8'hFF : w_count32[7:0];
  assign w_status   = {16'd0, w_countSat, 1'b0, w_rxFrameErr, r_txDrop,
                       w_rxOverrun, w_rxValid, (r_txState != TX_IDLE),
                       w_fifoEmpty, w_fifoFull};

  // Side-effect-free read mux; zero whenever the window is not addressed
  always_comb begin
    w_rdData = 32'd0;
    if (sel_o) begin
      case (addr_i[3:2])
        2'd1:    w_rdData = w_status;
        2'd2:    w_rdData = {16'd0, r_div};
        2'd3:    w_rdData = {23'd0, w_rxValid, w_rxByte};
        default: w_rdData = 32'd0;
      endcase
    end
  end

  assign data_o = w_rdData;

endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: directed and randomized checks of mmio_uart against a
// frame-level model of the serial line and the register rules.
module tb_mmio_uart;

  localparam logic [31:0] BASE     = 32'hFFFF_0000;
  localparam logic [31:0] OFS_TX   = 32'h0;
  localparam logic [31:0] OFS_STAT = 32'h4;
  localparam logic [31:0] OFS_DIV  = 32'h8;
  localparam logic [31:0] OFS_RX   = 32'hC;

  logic        clk;
  logic        reset;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        sel_o;
  logic        tx_o;
  logic        rx_i;

  int testsRun;
  int testsFailed;

  logic [7:0] txQ[$];

  mmio_uart #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (16'd434),
    .FIFO_DEPTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we_i  (we_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .data_o(data_o),
    .sel_o (sel_o),
    .tx_o  (tx_o),
    .rx_i  (rx_i)
  );

  // Free-running 100 MHz-style clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    we_i   = we;
    addr_i = addr;
    data_i = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One write cycle; returns at the falling edge after the capturing edge
  task automatic writeReg(input logic [31:0] ofs, input logic [31:0] data);
    applyStimulus(1'b1, BASE + ofs, data);
    @(negedge clk);
    applyStimulus(1'b0, BASE + OFS_STAT, 32'd0);
  endtask

  task automatic readReg(input logic [31:0] ofs, output logic [31:0] data);
    applyStimulus(1'b0, BASE + ofs, 32'd0);
    #1;
    data = data_o;
  endtask

  // Writes txQ back-to-back and compares tx_o/busy with the ideal 8N1 waveform
  task automatic runFrames(input string tag, input int div, output int busyCycles);
    logic expBits[$];
    int   n;
    int   total;
    int   waveErr;
    int   busyErr;
    logic expTx;
    logic expBusy;
    n          = txQ.size();
    waveErr    = 0;
    busyErr    = 0;
    busyCycles = 0;
    foreach (txQ[j]) begin
      for (int b = 0; b < 10; b++) begin
        logic v;
        v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : txQ[j][b-1];
        repeat (div + 1) expBits.push_back(v);
      end
    end
    total = expBits.size();
    applyStimulus(1'b1, BASE + OFS_TX, {24'd0, txQ[0]});
    @(negedge clk);
    for (int k = 1; k < total + 2 + 2 * (div + 1); k++) begin
      expTx = (k >= 2 && k - 2 < total) ? expBits[k-2] : 1'b1;
      if (tx_o !== expTx) waveErr++;
      if (addr_i == BASE + OFS_STAT) begin
        expBusy = (k >= 2 && k - 2 < total);
        if (data_o[2] === 1'b1) busyCycles++;
        if (data_o[2] !== expBusy) busyErr++;
      end
      if (k < n) applyStimulus(1'b1, BASE + OFS_TX, {24'd0, txQ[k]});
      else       applyStimulus(1'b0, BASE + OFS_STAT, 32'd0);
      @(negedge clk);
    end
    checkOutput({tag, " waveform bad cycles"}, 32'(waveErr), 32'd0);
    checkOutput({tag, " busy bad cycles"}, 32'(busyErr), 32'd0);
    txQ.delete();
  endtask

`ifdef MMIO_UART_RX_EN
  logic [7:0] expRxByte;
  logic       expRxValid;
  logic       expRxOverrun;
  logic       expRxFerr;

  // Register-level receive rules
  task automatic rxModel(input logic [7:0] b, input logic stopBit);
    if (!stopBit)        expRxFerr = 1'b1;
    else if (expRxValid) expRxOverrun = 1'b1;
    else begin
      expRxByte  = b;
      expRxValid = 1'b1;
    end
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit, input int div);
    rx_i = 1'b0;
    repeat (div + 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (div + 1) @(negedge clk);
    end
    rx_i = stopBit;
    repeat (div + 1) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * (div + 1) + 4) @(negedge clk);
    rxModel(b, stopBit);
  endtask

  task automatic checkRx(input string tag);
    logic [31:0] rd;
    readReg(OFS_STAT, rd);
    checkOutput({tag, " status rx bits"}, {25'd0, rd[6], 1'b0, rd[4:3], 3'd0},
                {25'd0, expRxFerr, 1'b0, expRxOverrun, expRxValid, 3'd0});
    readReg(OFS_RX, rd);
    checkOutput({tag, " rxdata"}, rd, {23'd0, expRxValid, expRxByte});
  endtask
`endif

  // Directed sequence with randomized data and divisors
  initial begin
    logic [31:0] rd;
    int          busy;
    int          div;
    int          n;
    logic [15:0] dv;
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    rx_i        = 1'b1;
    applyStimulus(1'b0, BASE + OFS_STAT, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("reset tx_o", 32'(tx_o), 32'd1);
    readReg(OFS_STAT, rd);
    checkOutput("reset status", rd, 32'h0000_0002);
    checkOutput("reset sel_o", 32'(sel_o), 32'd1);
    readReg(OFS_DIV, rd);
    checkOutput("reset div", rd, 32'd434);
    readReg(OFS_RX, rd);
    checkOutput("reset rxdata", rd, 32'd0);
    readReg(OFS_TX, rd);
    checkOutput("txdata reads zero", rd, 32'd0);
    @(negedge clk);

    writeReg(OFS_DIV, 32'd3);
    txQ.push_back(8'hA5);
    runFrames("frame A5 div3", 3, busy);
    checkOutput("busy clocks A5", 32'(busy), 32'd40);

    writeReg(OFS_DIV, 32'd2);
    txQ.push_back(8'h11);
    txQ.push_back(8'h22);
    runFrames("back-to-back 11/22", 2, busy);

    for (int it = 0; it < 4; it++) begin
      div = int'($urandom_range(1, 5));
      n   = int'($urandom_range(2, 5));
      writeReg(OFS_DIV, 32'(div));
      for (int j = 0; j < n; j++) txQ.push_back(8'($urandom));
      runFrames($sformatf("random run %0d", it), div, busy);
    end

    writeReg(OFS_DIV, 32'd0);
    readReg(OFS_DIV, rd);
    checkOutput("div write zero", rd, 32'd1);
    for (int it = 0; it < 3; it++) begin
      dv = 16'($urandom);
      writeReg(OFS_DIV, {16'($urandom), dv});
      readReg(OFS_DIV, rd);
      checkOutput($sformatf("div readback %0d", it), rd, {16'd0, (dv == 16'd0) ? 16'd1 : dv});
    end
    @(negedge clk);

    applyStimulus(1'b0, BASE + 32'h10, 32'd0);
    #1;
    checkOutput("outside sel_o", 32'(sel_o), 32'd0);
    checkOutput("outside data_o", data_o, 32'd0);
    applyStimulus(1'b0, BASE - 32'h4, 32'd0);
    #1;
    checkOutput("below base sel_o", 32'(sel_o), 32'd0);
    @(negedge clk);
    writeReg(32'h10, 32'h5A);
    writeReg(32'h18, 32'h77);
    readReg(OFS_STAT, rd);
    checkOutput("outside write status", rd, 32'h0000_0002);
    readReg(OFS_DIV, rd);
    checkOutput("outside write div", rd, {16'd0, dv == 16'd0 ? 16'd1 : dv});
    repeat (3) @(negedge clk);
    checkOutput("outside write tx idle", 32'(tx_o), 32'd1);

    writeReg(OFS_DIV, 32'd100);
    for (int j = 0; j < 9; j++) begin
      applyStimulus(1'b1, BASE + OFS_TX, {24'd0, 8'($urandom) & ((j == 0) ? 8'hFE : 8'hFF)});
      @(negedge clk);
    end
    readReg(OFS_STAT, rd);
    checkOutput("fifo full after 9", rd, 32'h0000_0805);
    writeReg(OFS_TX, 32'hEE);
    readReg(OFS_STAT, rd);
    checkOutput("tx_drop set", rd, 32'h0000_0825);
    writeReg(OFS_STAT, 32'd0);
    readReg(OFS_STAT, rd);
    checkOutput("tx_drop cleared", rd, 32'h0000_0805);
    @(negedge clk);
    repeat (139) @(negedge clk);
    checkOutput("tx low in data bit0", 32'(tx_o), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("tx high in reset", 32'(tx_o), 32'd1);
    readReg(OFS_STAT, rd);
    checkOutput("status in reset", rd, 32'h0000_0002);
    readReg(OFS_DIV, rd);
    checkOutput("div in reset", rd, 32'd434);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    readReg(OFS_STAT, rd);
    checkOutput("status after reset", rd, 32'h0000_0002);
    checkOutput("tx idle after reset", 32'(tx_o), 32'd1);
    @(negedge clk);

`ifdef MMIO_UART_RX_EN
    expRxByte    = 8'd0;
    expRxValid   = 1'b0;
    expRxOverrun = 1'b0;
    expRxFerr    = 1'b0;
    writeReg(OFS_DIV, 32'd7);
    sendRx(8'h3C, 1'b1, 7);
    checkRx("rx 3C");
    sendRx(8'h55, 1'b1, 7);
    checkRx("rx 55 overrun");
    writeReg(OFS_STAT, 32'd0);
    expRxOverrun = 1'b0;
    checkRx("rx status clear");
    @(negedge clk);
    writeReg(OFS_RX, 32'd0);
    expRxValid = 1'b0;
    checkRx("rx valid clear");
    @(negedge clk);
    sendRx(8'h5A, 1'b0, 7);
    checkRx("rx frame error");
    writeReg(OFS_STAT, 32'd0);
    expRxFerr = 1'b0;
    @(negedge clk);
    sendRx(8'($urandom), 1'b1, 7);
    checkRx("rx random byte");
`else
    for (int j = 0; j < 40; j++) begin
      rx_i = 1'($urandom);
      @(negedge clk);
    end
    rx_i = 1'b1;
    readReg(OFS_STAT, rd);
    checkOutput("rx bits absent", rd & 32'h0000_0058, 32'd0);
    readReg(OFS_RX, rd);
    checkOutput("rxdata absent", rd, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mmio_uart.md
# mmio_uart

Memory-mapped UART peripheral on the CPU's RAM port, downstream of the `cpu` top. It decodes `addr_o`/`we_o`/`data_o` from the core and returns read data for the system read mux. It buffers transmit bytes in a FIFO and serialises them as 8N1 frames. A receive path is available behind a compile-time switch.

## Interface
Parameters:
- BASE_ADDR, 32'hFFFF_0000 — 16-byte-aligned base of the register window.
- CLK_DIV, 16'd434 — reset value of the divisor register; bit period is DIV+1 clocks.
- FIFO_DEPTH, 8 — TX FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- we_i  in  1  write strobe from the CPU `we_o`.
- addr_i  in  32  byte address from the CPU `addr_o`.
- data_i  in  32  write data from the CPU `data_o`.
- data_o  out  32  combinational read data; 0 when not selected.
- sel_o  out  1  combinational; 1 when `addr_i[31:4] == BASE_ADDR[31:4]`; steers the read mux.
- tx_o  out  1  serial output; idles high.
- rx_i  in  1  serial input; asynchronous to clk.

## Operation
- Register select uses `addr_i[3:2]`.
- Reads are side-effect free, because the core has no read strobe.
- Writes act only when `we_i & sel_o`.
- 0x0 TXDATA
  - Write: push `data_i[7:0]` if count < FIFO_DEPTH; otherwise drop the byte and set sticky `tx_drop`.
  - Read: returns 0.
- 0x4 STATUS, read-only except for clearing:
  - bit0 tx_full, bit1 tx_empty, bit2 tx_busy (FSM not IDLE)
  - bit3 rx_valid, bit4 rx_overrun, bit5 tx_drop, bit6 rx_frame_err
  - [15:8] FIFO count, saturating at 255
  - Any write clears bits 4, 5 and 6.
- 0x8 DIV: read/write, bits [15:0]. A write of 0 stores 1.
- 0xC RXDATA
  - Read: `{23'b0, rx_valid, rx_byte}`.
  - Any write clears rx_valid.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - IDLE pops the FIFO head whenever the FIFO is not empty.
  - STOP goes straight to the next START if the FIFO is not empty at the end of STOP.
- Bit timer: reloads from DIV at the start of every bit and counts down to 0. A DIV change mid-frame takes effect at the next bit boundary.
- Simultaneous push and pop: both occur and the count is unchanged. The full check uses the pre-edge count.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider than the pointers.
- Reset values:
  - tx_o = 1; FIFO empty with count 0; FSM IDLE.
  - DIV = CLK_DIV; all status flags 0; rx_byte = 0.
- Reset mid-frame aborts the frame immediately, driving tx_o high asynchronously.

## Timing
- sel_o and data_o: combinational from addr_i and registered state, valid in the same cycle.
- TXDATA write captured at edge E with FSM idle and FIFO empty:
  - The pop occurs at edge E+1.
  - tx_o goes low after E+1.
- Each bit lasts exactly DIV+1 clocks. A frame is 10×(DIV+1) clocks.
- Back-to-back frames have no idle gap.
- STATUS reflects a push or pop from the edge that performs it onward.

## Configuration
- Macro: MMIO_UART_RX_EN.
- Defined: the RX path is built.
  - rx_i passes through a 2-flop synchroniser.
  - A falling edge starts the receiver. The start bit is re-sampled after (DIV+1)/2 clocks; if it reads high, the receiver returns to idle (glitch).
  - The 8 data bits and the stop bit are sampled at bit centres, DIV+1 clocks apart.
  - Stop bit = 0: set rx_frame_err and discard the byte.
  - Good frame with rx_valid already 1: set rx_overrun and keep the old byte.
  - Otherwise: load rx_byte and set rx_valid.
  - rx_valid and the byte load one edge after the stop-bit sample.
- Not defined: rx_i is ignored. STATUS bits 3, 4 and 6 read 0, and RXDATA reads 0.

## Test plan
- Reset, then write DIV=3 and TXDATA=0xA5 → tx_o low for 4 clocks, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then high for 4 clocks; tx_busy is 1 for exactly 40 clocks.
- Write 9 bytes with FIFO_DEPTH=8 while DIV=100 → 1 byte goes to the FSM and 8 fill the FIFO, so STATUS[15:8]=8 and tx_full=1. A 10th write sets tx_drop. A STATUS write clears it.
- Write 0x11 and 0x22 back-to-back → the STOP bit of the first frame is followed immediately by the START bit of the second, with no idle clock.
- Read from BASE_ADDR+0x10 → sel_o=0 and data_o=0. Write there → no state change.
- Assert reset mid-DATA bit → tx_o is high immediately, count=0, and DIV reverts to CLK_DIV.
- With MMIO_UART_RX_EN, drive 0x3C at DIV=7, then 0x55 without clearing → RXDATA reads 0x13C and rx_overrun=1. A frame with stop=0 sets rx_frame_err only.
